ysyx_23060240_csr_file: RTL

Machine-mode CSR file for the single-issue core, parametrised in XLEN and driven by the decode/execute stage. It implements full CSRRW/CSRRS/CSRRC read-modify-write semantics, ecall/mret trap sequencing with mstatus MIE/MPIE stacking, and a free-running 64-bit mcycle counter. It also flags illegal CSR accesses and supplies the redirect target to the fetch stage.

---
 rtl/ysyx_23060240_csr_file.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060240_csr_file.sv
// Machine-mode CSR file: CSRRW/CSRRS/CSRRC read-modify-write, ecall/mret trap
// sequencing with MIE/MPIE stacking, and a free-running 64-bit mcycle counter.
// Optional machine timer interrupt (mie/mip, async trap) is enabled by defining
// the macro YSYX_23060240_CSR_IRQ_EN.
module ysyx_23060240_csr_file #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            ecall,
    input  logic            mret,
`ifdef YSYX_23060240_CSR_IRQ_EN
    input  logic            irq_timer,
`endif
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_target
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
`ifdef YSYX_23060240_CSR_IRQ_EN
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
`endif

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     mcycle_q, mcycle_d;
`ifdef YSYX_23060240_CSR_IRQ_EN
    logic            mtie_q, mtie_d;
`endif

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] read_val;
    logic            addr_impl;
    logic [XLEN-1:0] write_val;
    logic            csr_write;
    logic            irq_take;

    // Assemble the architectural view of mstatus (MPP hardwired to M-mode)
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
    end

    // Decode the CSR address into its current value and an implemented flag
    always_comb begin
        read_val  = '0;
        addr_impl = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  read_val = mstatus_rd;
            ADDR_MTVEC:    read_val = mtvec_q;
            ADDR_MSCRATCH: read_val = mscratch_q;
            ADDR_MEPC:     read_val = mepc_q;
            ADDR_MCAUSE:   read_val = mcause_q;
            ADDR_MCYCLE:   read_val = mcycle_q[XLEN-1:0];
            ADDR_MCYCLEH: begin
                if (XLEN == 32) read_val = XLEN'(mcycle_q[63:32]);
                else            addr_impl = 1'b0;
            end
`ifdef YSYX_23060240_CSR_IRQ_EN
            ADDR_MIE: read_val[7] = mtie_q;
            ADDR_MIP: read_val[7] = irq_timer;
`endif
            default: addr_impl = 1'b0;
        endcase
    end

    // Read-modify-write value and whether a CSR write actually commits this cycle
    always_comb begin
        case (csr_op)
            OP_RW:   write_val = csr_wdata;
            OP_RS:   write_val = read_val | csr_wdata;
            OP_RC:   write_val = read_val & ~csr_wdata;
            default: write_val = read_val;
        endcase
`ifdef YSYX_23060240_CSR_IRQ_EN
        irq_take = mie_q & mtie_q & irq_timer & ~ecall & ~mret;
`else
        irq_take = 1'b0;
`endif
        csr_write = addr_impl && !ecall && !mret && !irq_take &&
                    ((csr_op == OP_RW) || ((csr_op != OP_NONE) && (csr_wdata != '0)));
    end

    // Combinational outputs: read port, illegal flag and fetch redirect
    always_comb begin
        csr_rdata   = read_val;
        csr_illegal = (csr_op != OP_NONE) && !addr_impl;
        trap_valid  = ecall | mret | irq_take;
        if (ecall)         trap_target = mtvec_q;
        else if (mret)     trap_target = mepc_q;
        else if (irq_take) trap_target = mtvec_q;
        else               trap_target = '0;
    end

    // Next-state: traps take priority over CSR writes; mcycle counts unless written
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
`ifdef YSYX_23060240_CSR_IRQ_EN
        mtie_d     = mtie_q;
`endif
        if (ecall) begin
            mepc_d   = pc & ALIGN_MASK;
            mcause_d = XLEN'(11);
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (irq_take) begin
            mepc_d   = pc & ALIGN_MASK;
            mcause_d = {1'b1, (XLEN-1)'(7)};
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (csr_write) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = write_val[3];
                    mpie_d = write_val[7];
                end
                ADDR_MTVEC:    mtvec_d    = write_val & ALIGN_MASK;
                ADDR_MSCRATCH: mscratch_d = write_val;
                ADDR_MEPC:     mepc_d     = write_val & ALIGN_MASK;
                ADDR_MCAUSE:   mcause_d   = write_val;
                ADDR_MCYCLE: begin
                    if (XLEN == 32) mcycle_d = {mcycle_q[63:32], write_val[31:0]};
                    else            mcycle_d = 64'(write_val);
                end
                ADDR_MCYCLEH:  mcycle_d = {write_val[31:0], mcycle_q[31:0]};
`ifdef YSYX_23060240_CSR_IRQ_EN
                ADDR_MIE:      mtie_d = write_val[7];
`endif
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset overriding every update
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
`ifdef YSYX_23060240_CSR_IRQ_EN
            mtie_q     <= 1'b0;
`endif
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
`ifdef YSYX_23060240_CSR_IRQ_EN
            mtie_q     <= mtie_d;
`endif
        end
    end

endmodule
